mem_arbiter: RTL and testbench

Downstream neighbour of the store/load buffer (SLB): arbitrates the single byte-wide RAM port between data accesses from the SLB and instruction fetches from the IF stage. Serialises each 1/2/4-byte request into byte beats, assembles little-endian read data, and returns a one-cycle finish pulse with result and source tags. Owns the `fc` side of every SLB handshake (`is_stall`/`is_finish`/`is_instr`/`is_store`).

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial RAM port shared between SLB data accesses and instruction fetch
module mem_arbiter #(
  parameter int AddrLength = 31,
  parameter int DataLength = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  is_exception_from_rob,
  input  logic [AddrLength:0]   addr_from_slb,
  input  logic [DataLength:0]   data_from_slb,
  input  logic [1:0]            aim_from_slb,
  input  logic                  is_empty_from_slb,
  input  logic                  is_store_from_slb,
  output logic [DataLength:0]   data_to_slb,
  output logic                  is_finish_to_slb,
  output logic                  is_stall_to_slb,
  output logic                  is_instr_to_slb,
  output logic                  is_store_to_slb,
  input  logic [AddrLength:0]   pc_from_if,
  input  logic                  is_req_from_if,
  output logic [DataLength:0]   instr_to_if,
  output logic                  is_finish_to_if,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [AddrLength:0]   mem_a,
  output logic                  mem_wr
);
  typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;
  state_t state, state_n;
  logic [2:0] cnt, n;
  logic [1:0] aim, idx, s_aim, pend_aim;
  logic last, flush, live, accept_slb, accept_if, s_store, pend_v, pend_store;
  logic [AddrLength:0] s_addr, pend_addr;
  logic [DataLength:0] s_data, pend_data, sdata, rbuf, asm;
  // request selection, beat bookkeeping, byte assembly and next state
  always_comb begin
    flush = is_exception_from_rob;
    s_addr = pend_v ? pend_addr : addr_from_slb;
    s_data = pend_v ? pend_data : data_from_slb;
    s_aim = pend_v ? pend_aim : aim_from_slb;
    s_store = pend_v ? pend_store : is_store_from_slb;
    live = !is_empty_from_slb && (is_store_from_slb || !flush);
    accept_slb = pend_v ? (pend_store || !flush) : live;
    accept_if = !accept_slb && is_req_from_if && !is_finish_to_if && !flush;
    n = (state == IFETCH || aim == 2'b00 || aim == 2'b11) ? 3'd4 : (aim == 2'b01) ? 3'd1 : 3'd2;
    last = (state == STORE) ? (cnt + 3'd1 == n) : (cnt == n);
    idx = cnt[1:0] - 2'd1;
    asm = rbuf;
    asm[{idx, 3'b000} +: 8] = mem_din;
    state_n = state;
    if (state == IDLE)
      state_n = accept_slb ? (s_store ? STORE : LOAD) : accept_if ? IFETCH : IDLE;
    else if (state == STORE)
      state_n = last ? IDLE : STORE;
    else
      state_n = (flush || last) ? IDLE : state;
  end
  always_comb is_stall_to_slb = (state != IDLE) || pend_v;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  // one-entry pending slot; a live pulse accepted straight from IDLE is not parked
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pend_v <= 1'b0;
      pend_store <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      pend_aim <= 2'b00;
    end else if (live && !(state == IDLE && !pend_v)) begin
      pend_v <= 1'b1;
      pend_store <= is_store_from_slb;
      pend_addr <= addr_from_slb;
      pend_data <= data_from_slb;
      pend_aim <= aim_from_slb;
    end else if ((state == IDLE && pend_v) || (flush && !pend_store)) begin
      pend_v <= 1'b0;
    end
  // RAM beats, read assembly and finish pulses; stores ignore flush
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= 3'd0;
      aim <= 2'b00;
      sdata <= '0;
      rbuf <= '0;
      mem_a <= '0;
      mem_wr <= 1'b0;
      mem_dout <= 8'h00;
      data_to_slb <= '0;
      instr_to_if <= '0;
      is_finish_to_slb <= 1'b0;
      is_finish_to_if <= 1'b0;
      is_instr_to_slb <= 1'b0;
      is_store_to_slb <= 1'b0;
    end else begin
      is_finish_to_slb <= 1'b0;
      is_finish_to_if <= 1'b0;
      is_instr_to_slb <= 1'b0;
      is_store_to_slb <= 1'b0;
      if (state == IDLE) begin
        cnt <= 3'd0;
        rbuf <= '0;
        if (accept_slb) begin
          mem_a <= s_addr;
          mem_wr <= s_store;
          mem_dout <= s_data[7:0];
          sdata <= s_data;
          aim <= s_aim;
        end else if (accept_if) begin
          mem_a <= pc_from_if;
          mem_wr <= 1'b0;
        end
      end else if (state == STORE) begin
        cnt <= cnt + 3'd1;
        if (last) begin
          mem_wr <= 1'b0;
          is_finish_to_slb <= 1'b1;
          is_store_to_slb <= 1'b1;
        end else begin
          mem_a <= mem_a + 1'b1;
          mem_dout <= sdata[15:8];
          sdata <= sdata >> 8;
        end
      end else if (!flush) begin
        cnt <= cnt + 3'd1;
        if (cnt + 3'd1 < n) mem_a <= mem_a + 1'b1;
        if (cnt != 3'd0) rbuf <= asm;
        if (last) begin
          is_finish_to_slb <= 1'b1;
          is_instr_to_slb <= (state == IFETCH);
          is_finish_to_if <= (state == IFETCH);
          if (state == IFETCH) instr_to_if <= asm;
          else data_to_slb <= asm;
        end
      end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus corner-case sequences for mem_arbiter
module tb_mem_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic is_exception_from_rob = 1'b0, is_empty_from_slb = 1'b1, is_store_from_slb = 1'b0;
  logic [31:0] addr_from_slb = '0, data_from_slb = '0, pc_from_if = '0;
  logic [1:0] aim_from_slb = 2'b00;
  logic is_req_from_if = 1'b0;
  logic [31:0] data_to_slb, instr_to_if, mem_a;
  logic is_finish_to_slb, is_stall_to_slb, is_instr_to_slb, is_store_to_slb, is_finish_to_if, mem_wr;
  logic [7:0] mem_din, mem_dout;
  logic [7:0] ram [0:8191];
  int checks = 0, errors = 0;
  int kd, ki, nslb, nif, wr;
  logic [31:0] dd, iv;
  logic sd, it;
  typedef struct {
    bit is_if;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0] aim;
    bit st;
    logic [31:0] exp;
    int lat;
    int wr;
  } vec_t;
  vec_t v [10];

  mem_arbiter dut (
    .clk(clk), .rst(rst), .is_exception_from_rob(is_exception_from_rob),
    .addr_from_slb(addr_from_slb), .data_from_slb(data_from_slb), .aim_from_slb(aim_from_slb),
    .is_empty_from_slb(is_empty_from_slb), .is_store_from_slb(is_store_from_slb),
    .data_to_slb(data_to_slb), .is_finish_to_slb(is_finish_to_slb), .is_stall_to_slb(is_stall_to_slb),
    .is_instr_to_slb(is_instr_to_slb), .is_store_to_slb(is_store_to_slb),
    .pc_from_if(pc_from_if), .is_req_from_if(is_req_from_if), .instr_to_if(instr_to_if),
    .is_finish_to_if(is_finish_to_if), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  // synchronous byte RAM, preset while reset is low
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8192; i++) ram[i] <= 8'h00;
      ram[13'h1000] <= 8'h13; ram[13'h1001] <= 8'h05;
      ram[13'h0020] <= 8'h80; ram[13'h0021] <= 8'h99;
      ram[13'h0040] <= 8'h11; ram[13'h0041] <= 8'h22; ram[13'h0042] <= 8'h33; ram[13'h0043] <= 8'h44;
      ram[13'h0050] <= 8'hAB; ram[13'h0051] <= 8'hCD; ram[13'h0052] <= 8'h77;
      ram[13'h1FFF] <= 8'h5A; ram[13'h0000] <= 8'h01; ram[13'h0001] <= 8'h02; ram[13'h0002] <= 8'h03;
      mem_din <= 8'h00;
    end else begin
      if (mem_wr) ram[mem_a[12:0]] <= mem_dout;
      mem_din <= ram[mem_a[12:0]];
    end
  end

  function automatic logic [31:0] ramw(input logic [31:0] a);
    logic [12:0] b;
    b = a[12:0];
    return {ram[b + 13'd3], ram[b + 13'd2], ram[b + 13'd1], ram[b]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req_slb(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m, input logic s);
    addr_from_slb = a;
    data_from_slb = d;
    aim_from_slb = m;
    is_store_from_slb = s;
    is_empty_from_slb = 1'b0;
  endtask

  task automatic req_if(input logic [31:0] pc);
    pc_from_if = pc;
    is_req_from_if = 1'b1;
  endtask

  // observe a fixed window, recording the first data finish and the first fetch finish
  task automatic run(input int win, input int flush_at);
    kd = 0; ki = 0; nslb = 0; nif = 0; wr = 0; dd = '0; iv = '0; sd = 1'b0; it = 1'b0;
    is_exception_from_rob = (flush_at == 0);
    for (int k = 1; k <= win; k++) begin
      step();
      is_empty_from_slb = 1'b1;
      is_exception_from_rob = (k == flush_at);
      if (mem_wr) wr++;
      if (is_finish_to_slb) begin
        nslb++;
        if (!is_instr_to_slb && kd == 0) begin
          kd = k; dd = data_to_slb; sd = is_store_to_slb;
        end
      end
      if (is_finish_to_if) begin
        nif++;
        if (ki == 0) begin
          ki = k; iv = instr_to_if; it = is_instr_to_slb && is_finish_to_slb && !is_store_to_slb;
        end
        is_req_from_if = 1'b0;
      end
    end
    is_exception_from_rob = 1'b0;
  endtask

  initial begin
    v[0] = '{1'b1, 32'h0000_1000, 32'h0, 2'b00, 1'b0, 32'h0000_0513, 6, 0};
    v[1] = '{1'b0, 32'h0000_0020, 32'h0, 2'b01, 1'b0, 32'h0000_0080, 3, 0};
    v[2] = '{1'b0, 32'h0000_0030, 32'hDEAD_BEEF, 2'b10, 1'b1, 32'h0000_BEEF, 3, 2};
    v[3] = '{1'b0, 32'h0000_0040, 32'h0, 2'b00, 1'b0, 32'h4433_2211, 6, 0};
    v[4] = '{1'b0, 32'h0000_0040, 32'h0, 2'b11, 1'b0, 32'h4433_2211, 6, 0};
    v[5] = '{1'b0, 32'h0000_0050, 32'h0, 2'b10, 1'b0, 32'h0000_CDAB, 4, 0};
    v[6] = '{1'b0, 32'h0000_0060, 32'h1234_5677, 2'b01, 1'b1, 32'h0000_0077, 2, 1};
    v[7] = '{1'b0, 32'h0000_0070, 32'hCAFE_F00D, 2'b00, 1'b1, 32'hCAFE_F00D, 5, 4};
    v[8] = '{1'b0, 32'hFFFF_FFFF, 32'h0, 2'b00, 1'b0, 32'h0302_015A, 6, 0};
    v[9] = '{1'b1, 32'h0000_0040, 32'h0, 2'b00, 1'b0, 32'h4433_2211, 6, 0};
    repeat (3) step();
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_flags", {31'h0, mem_wr | is_stall_to_slb | is_finish_to_slb | is_finish_to_if | is_instr_to_slb | is_store_to_slb}, 32'h0);
    chk("rst_data", data_to_slb | instr_to_if, 32'h0);
    rst = 1'b1;
    step();
    // reset pulled low in the middle of a word load
    req_slb(32'h40, 32'h0, 2'b00, 1'b0);
    step();
    is_empty_from_slb = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midrst_flags", {31'h0, mem_wr | is_stall_to_slb | is_finish_to_slb | is_finish_to_if}, 32'h0);
    chk("midrst_mem_a", mem_a, 32'h0);
    step();
    rst = 1'b1;
    run(10, -1);
    chk("midrst_no_finish", nslb + nif, 0);
    chk("midrst_no_write", wr, 0);
    // single transactions from the table
    for (int i = 0; i < 10; i++) begin
      if (v[i].is_if) req_if(v[i].addr);
      else req_slb(v[i].addr, v[i].data, v[i].aim, v[i].st);
      run(14, -1);
      if (v[i].is_if) begin
        chk($sformatf("v%0d_lat", i), ki, v[i].lat);
        chk($sformatf("v%0d_instr", i), iv, v[i].exp);
        chk($sformatf("v%0d_itag", i), {31'h0, it}, 32'h1);
        chk($sformatf("v%0d_nif", i), nif, 1);
      end else begin
        chk($sformatf("v%0d_lat", i), kd, v[i].lat);
        chk($sformatf("v%0d_data", i), v[i].st ? ramw(v[i].addr) : dd, v[i].exp);
        chk($sformatf("v%0d_stag", i), {31'h0, sd}, {31'h0, v[i].st});
        chk($sformatf("v%0d_nif", i), nif, 0);
        chk($sformatf("v%0d_wr", i), wr, v[i].wr);
      end
      chk($sformatf("v%0d_nslb", i), nslb, 1);
    end
    // fetch and word load requested in the same cycle: load goes first
    req_if(32'h1000);
    req_slb(32'h40, 32'h0, 2'b00, 1'b0);
    run(20, -1);
    chk("both_ld_lat", kd, 6);
    chk("both_ld_data", dd, 32'h4433_2211);
    chk("both_if_lat", ki, 12);
    chk("both_if_instr", iv, 32'h0000_0513);
    chk("both_nslb", nslb, 2);
    // SLB pulse during a fetch is parked and served right after it
    req_if(32'h40);
    step();
    step();
    req_slb(32'h20, 32'h0, 2'b01, 1'b0);
    step();
    is_empty_from_slb = 1'b1;
    chk("park_stall", {31'h0, is_stall_to_slb}, 32'h1);
    run(14, -1);
    chk("park_if_lat", ki, 3);
    chk("park_if_instr", iv, 32'h4433_2211);
    chk("park_ld_lat", kd, 6);
    chk("park_ld_data", dd, 32'h0000_0080);
    // flush during a load aborts it silently
    req_slb(32'h40, 32'h0, 2'b00, 1'b0);
    run(14, 2);
    chk("flush_ld_nfin", nslb + nif, 0);
    chk("flush_ld_stall", {31'h0, is_stall_to_slb}, 32'h0);
    // load pulse coincident with flush is ignored
    req_slb(32'h20, 32'h0, 2'b01, 1'b0);
    run(8, 0);
    chk("flush_pulse_nfin", nslb, 0);
    chk("flush_pulse_stall", {31'h0, is_stall_to_slb}, 32'h0);
    // flush during a word store does not stop it
    req_slb(32'h80, 32'h0BAD_F00D, 2'b00, 1'b1);
    run(14, 2);
    chk("flush_st_lat", kd, 5);
    chk("flush_st_tag", {31'h0, sd}, 32'h1);
    chk("flush_st_wr", wr, 4);
    chk("flush_st_ram", ramw(32'h80), 32'h0BAD_F00D);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
